mem_access_unit: RTL and testbench

Data-memory responder for the LoongArch32 core. It accepts one load/store request per transaction from the execute stage, decoded from the control unit's memRead/memWriteEn and load/store type. It drives the synchronous data SRAM with aligned address, byte strobes and replicated store data, then returns sign/zero-extended load data with the destination register through a valid/ready handshake. It sits between the EX/MEM pipeline register and the data SRAM port and stalls the pipeline while a request is outstanding.

---
 rtl/mem_access_unit_pkg.sv | 45 ++++
 rtl/mem_access_unit_if.sv | 43 ++++
 rtl/mem_access_unit_load_align.sv | 26 ++
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the data-memory access unit.
package mem_access_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4,
    ST_B  = 3'd5,
    ST_H  = 3'd6,
    ST_W  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  // Accepted transaction context kept until the response is produced.
  typedef struct packed {
    mem_op_e          op;
    logic [1:0]       off;
    logic [REG_W-1:0] rd;
  } txn_t;

  function automatic logic is_load(input mem_op_e op);
    return op inside {LD_B, LD_H, LD_W, LD_BU, LD_HU};
  endfunction

  function automatic logic is_aligned(input mem_op_e op, input logic [1:0] off);
    case (op)
      LD_H, LD_HU, ST_H: return ~off[0];
      LD_W, ST_W:        return off == 2'b00;
      default:           return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake and data SRAM port of the memory access unit.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic              req_valid;
  logic              req_ready;
  mem_op_e           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [REG_W-1:0]  req_rd;
  logic              flush;

  logic              data_sram_en;
  logic [STRB_W-1:0] data_sram_we;
  logic [ADDR_W-1:0] data_sram_addr;
  logic [DATA_W-1:0] data_sram_wdata;
  logic [DATA_W-1:0] data_sram_rdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [REG_W-1:0]  resp_rd;
  logic              resp_we;
  logic              resp_ale;
  logic              stall;

  // Pipeline/SRAM side that issues requests and returns read data.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd, flush, resp_ready,
    output data_sram_rdata,
    input  req_ready, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  resp_valid, resp_data, resp_rd, resp_we, resp_ale, stall
  );

  // The memory access unit itself.
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd, flush, resp_ready,
    input  data_sram_rdata,
    output req_ready, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output resp_valid, resp_data, resp_rd, resp_we, resp_ale, stall
  );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed byte/halfword of an SRAM word and sign/zero-extends it.
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  mem_op_e           op,
  output logic [DATA_W-1:0] ext_c
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    ext_c   = '0;
    case (op)
      LD_B:    ext_c = {{24{shifted[7]}}, shifted[7:0]};
      LD_BU:   ext_c = {24'h0, shifted[7:0]};
      LD_H:    ext_c = {{16{shifted[15]}}, shifted[15:0]};
      LD_HU:   ext_c = {16'h0, shifted[15:0]};
      LD_W:    ext_c = rdata;
      default: ext_c = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory responder: drives the data SRAM for one load/store at a time and
// returns extended load data over a valid/ready response channel.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input logic               clk,
  input logic               resetn,
  mem_access_unit_if.slave  bus
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] S_IDLE = MEM_IDLE;
  localparam logic [1:0] S_WAIT = MEM_WAIT;
  localparam logic [1:0] S_RESP = MEM_RESP;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              drop, drop_nxt;
  txn_t              txn, txn_nxt;

  logic              resp_valid_q, resp_valid_nxt;
  logic [DATA_W-1:0] resp_data_q, resp_data_nxt;
  logic [REG_W-1:0]  resp_rd_q, resp_rd_nxt;
  logic              resp_we_q, resp_we_nxt;
  logic              resp_ale_q, resp_ale_nxt;

  logic              idle;
  logic              accept;
  logic              req_aligned;
  logic              req_load;
  logic [1:0]        req_off;
  logic [DATA_W-1:0] load_ext_c;

  assign idle        = (state == S_IDLE);
  assign req_off     = bus.req_addr[1:0];
  assign req_aligned = is_aligned(bus.req_op, req_off);
  assign req_load    = is_load(bus.req_op);

  // Flush in IDLE withholds ready so it always wins over a new request.
  assign bus.req_ready = idle & ~bus.flush;
  assign accept        = bus.req_valid & bus.req_ready;
  assign bus.stall     = ~idle | (bus.req_valid & req_load);

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.resp_we    = resp_we_q;
  assign bus.resp_ale   = resp_ale_q;

  // SRAM is driven only in the accept cycle of an aligned request.
  always_comb begin
    bus.data_sram_en    = 1'b0;
    bus.data_sram_we    = '0;
    bus.data_sram_addr  = '0;
    bus.data_sram_wdata = '0;
    if (accept && req_aligned) begin
      bus.data_sram_en   = 1'b1;
      bus.data_sram_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
      case (bus.req_op)
        ST_B: begin
          bus.data_sram_we    = STRB_W'(4'b0001 << req_off);
          bus.data_sram_wdata = {4{bus.req_wdata[7:0]}};
        end
        ST_H: begin
          bus.data_sram_we    = STRB_W'(4'b0011 << req_off);
          bus.data_sram_wdata = {2{bus.req_wdata[15:0]}};
        end
        ST_W: begin
          bus.data_sram_we    = 4'b1111;
          bus.data_sram_wdata = bus.req_wdata;
        end
        default: ;
      endcase
    end
  end

  mem_access_unit_load_align u_load_align (
    .rdata (bus.data_sram_rdata),
    .off   (txn.off),
    .op    (txn.op),
    .ext_c (load_ext_c)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      drop         <= 1'b0;
      txn          <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_we_q    <= 1'b0;
      resp_ale_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      drop         <= drop_nxt;
      txn          <= txn_nxt;
      resp_valid_q <= resp_valid_nxt;
      resp_data_q  <= resp_data_nxt;
      resp_rd_q    <= resp_rd_nxt;
      resp_we_q    <= resp_we_nxt;
      resp_ale_q   <= resp_ale_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    drop_nxt       = drop;
    txn_nxt        = txn;
    resp_valid_nxt = resp_valid_q;
    resp_data_nxt  = resp_data_q;
    resp_rd_nxt    = resp_rd_q;
    resp_we_nxt    = resp_we_q;
    resp_ale_nxt   = resp_ale_q;

    case (state)
      S_IDLE: begin
        if (accept) begin
          txn_nxt = '{op: bus.req_op, off: req_off, rd: bus.req_rd};
          if (req_load && req_aligned) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_W'(RD_LAT - 1);
            drop_nxt  = 1'b0;
          end else begin
            // Stores and misaligned requests answer immediately.
            state_nxt      = S_RESP;
            resp_valid_nxt = 1'b1;
            resp_data_nxt  = '0;
            resp_rd_nxt    = req_load ? bus.req_rd : '0;
            resp_we_nxt    = 1'b0;
            resp_ale_nxt   = ~req_aligned;
          end
        end
      end

      S_WAIT: begin
        if (bus.flush) drop_nxt = 1'b1;
        if (cnt == '0) begin
          if (drop || bus.flush) begin
            state_nxt = S_IDLE;
            drop_nxt  = 1'b0;
          end else begin
            state_nxt      = S_RESP;
            resp_valid_nxt = 1'b1;
            resp_data_nxt  = load_ext_c;
            resp_rd_nxt    = txn.rd;
            resp_we_nxt    = 1'b1;
            resp_ale_nxt   = 1'b0;
          end
        end else begin
          cnt_nxt = CNT_W'(cnt - 1'b1);
        end
      end

      S_RESP: begin
        if (bus.resp_ready || bus.flush) begin
          state_nxt      = S_IDLE;
          resp_valid_nxt = 1'b0;
          resp_data_nxt  = '0;
          resp_rd_nxt    = '0;
          resp_we_nxt    = 1'b0;
          resp_ale_nxt   = 1'b0;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a fixed-latency SRAM model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int unsigned RD_LAT = 3;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  logic [31:0]       sram_word;
  logic [RD_LAT-1:0] rd_pipe;

  mem_access_unit_if bus ();

  mem_access_unit #(.RD_LAT(RD_LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data is only valid exactly RD_LAT cycles after a read enable.
  always @(posedge clk)
    rd_pipe <= RD_LAT'({rd_pipe, (bus.data_sram_en & (bus.data_sram_we == 4'b0000))});
  assign bus.data_sram_rdata = rd_pipe[RD_LAT-1] ? sram_word : 32'hBAD0_BAD0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    resetn = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = LD_B; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_rd = '0; bus.flush = 1'b0; bus.resp_ready = 1'b1;
    sram_word = '0; rd_pipe = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset resp_valid: got %b want 0", bus.resp_valid); end
    checks++; if (bus.resp_data !== 32'h0 || bus.resp_rd !== 5'd0) begin failures++; $display("FAIL reset resp_data/rd: got %h/%0d want 0/0", bus.resp_data, bus.resp_rd); end
    checks++; if (bus.resp_we !== 1'b0 || bus.resp_ale !== 1'b0) begin failures++; $display("FAIL reset resp_we/ale: got %b/%b want 0/0", bus.resp_we, bus.resp_ale); end
    checks++; if (bus.data_sram_en !== 1'b0 || bus.data_sram_we !== 4'h0 || bus.data_sram_addr !== 32'h0 || bus.data_sram_wdata !== 32'h0) begin
      failures++; $display("FAIL reset sram: got en=%b we=%h addr=%h wdata=%h want all 0", bus.data_sram_en, bus.data_sram_we, bus.data_sram_addr, bus.data_sram_wdata); end
    checks++; if (bus.req_ready !== 1'b1 || bus.stall !== 1'b0) begin failures++; $display("FAIL reset ready/stall: got %b/%b want 1/0", bus.req_ready, bus.stall); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store();
    mem_op_e     ops [3];
    logic [31:0] addrs [3], datas [3], exp_wd [3];
    logic [3:0]  exp_we [3];
    ops    = '{ST_W, ST_B, ST_H};
    addrs  = '{32'h0000_1000, 32'h0000_1003, 32'h0000_1006};
    datas  = '{32'hDEAD_BEEF, 32'h0000_00A5, 32'h0000_CAFE};
    exp_we = '{4'b1111, 4'b1000, 4'b1100};
    exp_wd = '{32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'hCAFE_CAFE};
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1; bus.req_op = ops[i]; bus.req_addr = addrs[i];
      bus.req_wdata = datas[i]; bus.req_rd = 5'd3;
      #1;
      checks++; if (bus.data_sram_en !== 1'b1 || bus.data_sram_we !== exp_we[i]) begin
        failures++; $display("FAIL store%0d en/we: got %b/%b want 1/%b", i, bus.data_sram_en, bus.data_sram_we, exp_we[i]); end
      checks++; if (bus.data_sram_addr !== {addrs[i][31:2], 2'b00} || bus.data_sram_wdata !== exp_wd[i]) begin
        failures++; $display("FAIL store%0d addr/wdata: got %h/%h want %h/%h", i, bus.data_sram_addr, bus.data_sram_wdata, {addrs[i][31:2], 2'b00}, exp_wd[i]); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL store%0d stall: got %b want 0", i, bus.stall); end
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_we !== 1'b0 || bus.resp_ale !== 1'b0) begin
        failures++; $display("FAIL store%0d resp: got valid=%b we=%b ale=%b want 1/0/0", i, bus.resp_valid, bus.resp_we, bus.resp_ale); end
      checks++; if (bus.resp_data !== 32'h0 || bus.resp_rd !== 5'd0 || bus.req_ready !== 1'b0) begin
        failures++; $display("FAIL store%0d resp data/rd/ready: got %h/%0d/%b want 0/0/0", i, bus.resp_data, bus.resp_rd, bus.req_ready); end
      @(negedge clk);
      checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        failures++; $display("FAIL store%0d done: got valid=%b ready=%b want 0/1", i, bus.resp_valid, bus.req_ready); end
    end
  endtask

  task automatic test_load();
    mem_op_e     ops [6];
    logic [31:0] addrs [6], words [6], exp_d [6];
    logic [4:0]  rds [6];
    ops   = '{LD_B, LD_BU, LD_H, LD_HU, LD_W, LD_H};
    addrs = '{32'h2002, 32'h2002, 32'h2000, 32'h2000, 32'h2000, 32'h2002};
    words = '{32'h0080_FF00, 32'h0080_FF00, 32'h0080_FF00, 32'h0080_FF00, 32'h1234_5678, 32'h8001_0000};
    exp_d = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FF00, 32'h0000_FF00, 32'h1234_5678, 32'hFFFF_8001};
    rds   = '{5'd7, 5'd7, 5'd3, 5'd4, 5'd31, 5'd1};
    for (int i = 0; i < 6; i++) begin
      sram_word = words[i];
      bus.req_valid = 1'b1; bus.req_op = ops[i]; bus.req_addr = addrs[i];
      bus.req_wdata = 32'hFFFF_FFFF; bus.req_rd = rds[i];
      #1;
      checks++; if (bus.data_sram_en !== 1'b1 || bus.data_sram_we !== 4'h0 || bus.data_sram_addr !== 32'h2000 || bus.stall !== 1'b1) begin
        failures++; $display("FAIL load%0d issue: got en=%b we=%h addr=%h stall=%b want 1/0/00002000/1", i, bus.data_sram_en, bus.data_sram_we, bus.data_sram_addr, bus.stall); end
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int c = 0; c < RD_LAT; c++) begin
        #1;
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.stall !== 1'b1) begin
          failures++; $display("FAIL load%0d wait%0d: got valid=%b ready=%b stall=%b want 0/0/1", i, c, bus.resp_valid, bus.req_ready, bus.stall); end
        @(negedge clk);
      end
      #1;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== exp_d[i]) begin
        failures++; $display("FAIL load%0d resp: got valid=%b data=%h want 1/%h", i, bus.resp_valid, bus.resp_data, exp_d[i]); end
      checks++; if (bus.resp_rd !== rds[i] || bus.resp_we !== 1'b1 || bus.resp_ale !== 1'b0) begin
        failures++; $display("FAIL load%0d rd/we/ale: got %0d/%b/%b want %0d/1/0", i, bus.resp_rd, bus.resp_we, bus.resp_ale, rds[i]); end
      @(negedge clk);
      checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL load%0d done: got valid=%b want 0", i, bus.resp_valid); end
    end
  endtask

  task automatic test_misaligned();
    mem_op_e     ops [3];
    logic [31:0] addrs [3];
    ops   = '{LD_H, LD_W, ST_W};
    addrs = '{32'h2001, 32'h2002, 32'h1001};
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1; bus.req_op = ops[i]; bus.req_addr = addrs[i];
      bus.req_wdata = 32'h5555_AAAA; bus.req_rd = 5'd9;
      #1;
      checks++; if (bus.data_sram_en !== 1'b0 || bus.data_sram_we !== 4'h0 || bus.req_ready !== 1'b1) begin
        failures++; $display("FAIL ale%0d sram: got en=%b we=%h ready=%b want 0/0/1", i, bus.data_sram_en, bus.data_sram_we, bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_ale !== 1'b1 || bus.resp_we !== 1'b0 || bus.resp_data !== 32'h0) begin
        failures++; $display("FAIL ale%0d resp: got valid=%b ale=%b we=%b data=%h want 1/1/0/0", i, bus.resp_valid, bus.resp_ale, bus.resp_we, bus.resp_data); end
      @(negedge clk);
      checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL ale%0d done: got valid=%b want 0", i, bus.resp_valid); end
    end
  endtask

  task automatic test_backpressure();
    sram_word = 32'h0080_FF00;
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = LD_B; bus.req_addr = 32'h2002; bus.req_rd = 5'd9;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (RD_LAT) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = ST_W; bus.req_addr = 32'h3000; bus.req_wdata = 32'h1111_2222;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hFFFF_FF80 || bus.resp_rd !== 5'd9 || bus.resp_ale !== 1'b0) begin
        failures++; $display("FAIL hold%0d resp: got valid=%b data=%h rd=%0d ale=%b want 1/ffffff80/9/0", c, bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_ale); end
      checks++; if (bus.req_ready !== 1'b0 || bus.data_sram_en !== 1'b0) begin
        failures++; $display("FAIL hold%0d ready/en: got %b/%b want 0/0", c, bus.req_ready, bus.data_sram_en); end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL hold release: got valid=%b want 1", bus.resp_valid); end
    @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL hold done: got valid=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready); end
  endtask

  task automatic test_flush_resp();
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = ST_W; bus.req_addr = 32'h1000; bus.req_wdata = 32'h0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL flush_resp pre: got valid=%b want 1", bus.resp_valid); end
    @(negedge clk);
    bus.flush = 1'b0;
    bus.resp_ready = 1'b1;
    #1;
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL flush_resp post: got valid=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready); end
    @(negedge clk);
  endtask

  // Abort a load in WAIT by flush (mode 0) or reset (mode 1), then issue ST_H cleanly.
  task automatic test_abort_wait(input int mode);
    sram_word = 32'h7777_7777;
    bus.req_valid = 1'b1; bus.req_op = LD_W; bus.req_addr = 32'h2000; bus.req_rd = 5'd5;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (mode == 0) bus.flush = 1'b1; else resetn = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0; resetn = 1'b1;
    for (int c = 0; c < RD_LAT; c++) begin
      #1;
      checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL abort%0d cycle%0d: got valid=%b want 0", mode, c, bus.resp_valid); end
      @(negedge clk);
    end
    checks++; if (bus.req_ready !== 1'b1 || bus.stall !== 1'b0) begin
      failures++; $display("FAIL abort%0d idle: got ready=%b stall=%b want 1/0", mode, bus.req_ready, bus.stall); end
    bus.req_valid = 1'b1; bus.req_op = ST_H; bus.req_addr = 32'h10; bus.req_wdata = 32'h0000_1234;
    #1;
    checks++; if (bus.data_sram_en !== 1'b1 || bus.data_sram_we !== 4'b0011 || bus.data_sram_addr !== 32'h10 || bus.data_sram_wdata !== 32'h1234_1234) begin
      failures++; $display("FAIL abort%0d st_h: got en=%b we=%b addr=%h wdata=%h want 1/0011/00000010/12341234", mode, bus.data_sram_en, bus.data_sram_we, bus.data_sram_addr, bus.data_sram_wdata); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_we !== 1'b0 || bus.resp_data !== 32'h0) begin
      failures++; $display("FAIL abort%0d st_h resp: got valid=%b we=%b data=%h want 1/0/0", mode, bus.resp_valid, bus.resp_we, bus.resp_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_resp();
    sram_word = 32'h0000_00F0;
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = LD_BU; bus.req_addr = 32'h2000; bus.req_rd = 5'd12;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (RD_LAT) @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h0000_00F0 || bus.resp_rd !== 5'd12) begin
      failures++; $display("FAIL rst_resp pre: got valid=%b data=%h rd=%0d want 1/000000f0/12", bus.resp_valid, bus.resp_data, bus.resp_rd); end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    bus.resp_ready = 1'b1;
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 || bus.resp_rd !== 5'd0 || bus.resp_we !== 1'b0) begin
      failures++; $display("FAIL rst_resp post: got valid=%b data=%h rd=%0d we=%b want 0/0/0/0", bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_we); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 1'b1; bus.req_op = ST_W; bus.req_addr = 32'h4000; bus.req_wdata = 32'hAAAA_5555;
    #1;
    checks++; if (bus.data_sram_en !== 1'b1) begin failures++; $display("FAIL b2b first en: got %b want 1", bus.data_sram_en); end
    @(negedge clk);
    bus.req_op = ST_B; bus.req_addr = 32'h1003; bus.req_wdata = 32'h0000_00A5;
    #1;
    checks++; if (bus.data_sram_en !== 1'b0 || bus.resp_valid !== 1'b1) begin
      failures++; $display("FAIL b2b gap: got en=%b valid=%b want 0/1", bus.data_sram_en, bus.resp_valid); end
    @(negedge clk);
    #1;
    checks++; if (bus.data_sram_en !== 1'b1 || bus.data_sram_we !== 4'b1000 || bus.data_sram_wdata !== 32'hA5A5_A5A5 || bus.resp_valid !== 1'b0) begin
      failures++; $display("FAIL b2b second: got en=%b we=%b wdata=%h valid=%b want 1/1000/a5a5a5a5/0", bus.data_sram_en, bus.data_sram_we, bus.data_sram_wdata, bus.resp_valid); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL b2b second resp: got valid=%b want 1", bus.resp_valid); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_backpressure();
    test_flush_resp();
    test_abort_wait(0);
    test_abort_wait(1);
    test_reset_resp();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
